// File: rtl/hdb3_tx_sched_if.sv
// Requester and encoder-side signal bundle for the HDB3 frame scheduler.
// The scheduler is the slave: it takes the channel data/valid pairs and
// drives the ready strobes plus the serial stream toward the encoder.
interface hdb3_tx_sched_if;
  logic [7:0] i_ch0_data;
  logic       i_ch0_valid;
  logic       o_ch0_ready;
  logic [7:0] i_ch1_data;
  logic       i_ch1_valid;
  logic       o_ch1_ready;
  logic       o_enc_data;
  logic       o_frame_start;
  logic       o_active_ch;
  logic       o_busy;
  logic       o_underrun;

  modport master (
    output i_ch0_data, i_ch0_valid, i_ch1_data, i_ch1_valid,
    input  o_ch0_ready, o_ch1_ready, o_enc_data, o_frame_start,
           o_active_ch, o_busy, o_underrun
  );

  modport slave (
    input  i_ch0_data, i_ch0_valid, i_ch1_data, i_ch1_valid,
    output o_ch0_ready, o_ch1_ready, o_enc_data, o_frame_start,
           o_active_ch, o_busy, o_underrun
  );
endinterface

// File: rtl/hdb3_tx_sched.sv
// Round-robin frame scheduler feeding one HDB3 encoder from two byte sources.
// Each frame is SYNC_WORD, a channel-ID byte, then FRAME_BYTES payload bytes,
// shifted out MSB-first one bit per clock, followed by MIN_GAP zero bits.
// The serial bit is the MSB of a shift register, so the encoder input is
// always a flop output.
module hdb3_tx_sched #(
  parameter int         FRAME_BYTES = 4,
  parameter logic [7:0] SYNC_WORD   = 8'h7E,
  parameter int         MIN_GAP     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  hdb3_tx_sched_if.slave   bus
);

  localparam int BYTE_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(MIN_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_CHID, S_PAYLOAD, S_GAP} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [7:0]          r_shift;
  logic [2:0]          r_bit_cnt;
  logic [BYTE_W-1:0]   r_byte_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic                r_gnt;
  logic                r_last_served;

  logic                w_last_bit;
  logic                w_req;
  logic                w_pick;
  logic                w_fetch;
  logic                w_gnt_valid;
  logic [7:0]          w_gnt_data;
  logic [7:0]          w_fetch_byte;

  // Arbitration pick, payload fetch strobe and the byte to load on a fetch.
  always_comb begin
    w_last_bit   = (r_bit_cnt == 3'd7);
    w_req        = bus.i_ch0_valid | bus.i_ch1_valid;
    // Both requesting: the channel not served last wins; otherwise the lone requester.
    w_pick       = (bus.i_ch0_valid & bus.i_ch1_valid) ? ~r_last_served : bus.i_ch1_valid;
    // A fetch happens on the last bit of the CHID byte and of every payload
    // byte except the final one, so the next byte is in the shifter in time.
    w_fetch      = w_last_bit & ((r_state == S_CHID) |
                                 ((r_state == S_PAYLOAD) & (r_byte_cnt != LAST_BYTE)));
    w_gnt_valid  = r_gnt ? bus.i_ch1_valid : bus.i_ch0_valid;
    w_gnt_data   = r_gnt ? bus.i_ch1_data  : bus.i_ch0_data;
    // A missing byte is replaced by zeros so the frame length never changes.
    w_fetch_byte = w_gnt_valid ? w_gnt_data : 8'h00;
  end

  // Next-state decode for the frame sequence.
  always_comb begin
    // NOTE: default first so every path assigns w_next_state; without it a
    // missed branch would infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:    if (w_req) w_next_state = S_SYNC;
      S_SYNC:    if (w_last_bit) w_next_state = S_CHID;
      S_CHID:    if (w_last_bit) w_next_state = S_PAYLOAD;
      S_PAYLOAD: if (w_last_bit && (r_byte_cnt == LAST_BYTE)) w_next_state = S_GAP;
      S_GAP:     if (r_gap_cnt == LAST_GAP) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments for all flops so every register samples
    // pre-edge values regardless of statement order.
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Shifter, bit/byte/gap counters and the latched grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift       <= 8'h00;
      r_bit_cnt     <= 3'd0;
      r_byte_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_gnt         <= 1'b0;
      r_last_served <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_gnt         <= w_pick;
            r_last_served <= w_pick;
            r_shift       <= SYNC_WORD;
            r_bit_cnt     <= 3'd0;
            r_byte_cnt    <= '0;
          end
        end
        S_SYNC, S_CHID, S_PAYLOAD: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_last_bit) begin
            if (r_state == S_SYNC) r_shift <= {7'b0, r_gnt};
            else if (w_fetch)      r_shift <= w_fetch_byte;
            else                   r_shift <= 8'h00;
            if ((r_state == S_PAYLOAD) && w_fetch) r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
            r_gap_cnt <= '0;
          end else begin
            r_shift <= {r_shift[6:0], 1'b0};
          end
        end
        S_GAP:   r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.o_enc_data    = r_shift[7];
  assign bus.o_frame_start = (r_state == S_SYNC) && (r_bit_cnt == 3'd0);
  assign bus.o_busy        = (r_state != S_IDLE);
  assign bus.o_active_ch   = r_gnt;
  assign bus.o_ch0_ready   = w_fetch & ~r_gnt;
  assign bus.o_ch1_ready   = w_fetch &  r_gnt;
  assign bus.o_underrun    = w_fetch & ~w_gnt_valid;

endmodule

// File: tb/tb_hdb3_tx_sched.sv
// Self-checking bench for hdb3_tx_sched: a frame-position reference model is
// compared against the DUT every cycle, and directed scenarios pin the model
// with hand-computed streams. A second instance covers the 1-byte/1-gap case.
module tb_hdb3_tx_sched;
  localparam int         FB   = 4;
  localparam int         GAP  = 2;
  localparam logic [7:0] SYNC = 8'h7E;
  localparam int         FLEN = 16 + 8 * FB;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  hdb3_tx_sched_if bus ();
  hdb3_tx_sched_if bus1 ();

  hdb3_tx_sched #(.FRAME_BYTES(FB), .SYNC_WORD(SYNC), .MIN_GAP(GAP)) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus));
  hdb3_tx_sched #(.FRAME_BYTES(1), .SYNC_WORD(SYNC), .MIN_GAP(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .bus(bus1));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- stimulus sources ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit en0 = 0, en1 = 0, rnd = 0, started = 0;
  int drop_pos1 = -2;

  // ---------------- reference model ----------------
  int         m_pos  = -1;       // frame-relative cycle, -1 when idle
  bit         m_last = 1'b1;     // last served channel
  bit         m_act  = 1'b0;     // channel owning the frame
  logic [7:0] m_frame [0:FB+1];  // bytes of the frame as transmitted
  logic       e_rdy, e_enc, gv, g;
  logic [7:0] gd;

  // ---------------- frame capture log ----------------
  int          cyc = 0, fcnt = 0, cap_pos = 0, cb = 0, cstart = 0;
  bit          cap_on = 0;
  logic [63:0] cs, cr, cu;
  logic        cch;
  logic [63:0] f_stream [0:63];
  logic [63:0] f_rdy    [0:63];
  logic [63:0] f_und    [0:63];
  int          f_busy   [0:63];
  int          f_start  [0:63];
  logic        f_ch     [0:63];

  // Source driver: presents queue heads just after each rising edge.
  initial begin
    bit v0, v1;
    bus.i_ch0_valid = 1'b0; bus.i_ch1_valid = 1'b0;
    bus.i_ch0_data  = 8'h00; bus.i_ch1_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rnd) begin
        while (q0.size() < 4) q0.push_back(8'($urandom));
        while (q1.size() < 4) q1.push_back(8'($urandom));
      end
      v0 = (rnd ? ($urandom_range(0, 3) != 0) : en0) && (q0.size() > 0);
      v1 = (rnd ? ($urandom_range(0, 3) != 0) : en1) && (q1.size() > 0) && (m_pos != drop_pos1);
      bus.i_ch0_valid = v0;
      bus.i_ch1_valid = v1;
      bus.i_ch0_data  = (q0.size() > 0) ? q0[0] : 8'($urandom);
      bus.i_ch1_data  = (q1.size() > 0) ? q1[0] : 8'($urandom);
    end
  end

  // Per-cycle compare against the model, frame capture, then model advance.
  always @(negedge clk) begin
    if (started) begin
      e_rdy = (m_pos >= 15) && (m_pos <= 15 + 8 * (FB - 1)) && ((m_pos - 15) % 8 == 0);
      e_enc = (m_pos >= 0 && m_pos < FLEN) ? m_frame[m_pos / 8][7 - (m_pos % 8)] : 1'b0;
      gv    = m_act ? bus.i_ch1_valid : bus.i_ch0_valid;
      gd    = m_act ? bus.i_ch1_data  : bus.i_ch0_data;
      check("busy",        bus.o_busy,        m_pos >= 0);
      check("frame_start", bus.o_frame_start, m_pos == 0);
      check("enc_data",    bus.o_enc_data,    e_enc);
      check("ch0_ready",   bus.o_ch0_ready,   e_rdy && !m_act);
      check("ch1_ready",   bus.o_ch1_ready,   e_rdy && m_act);
      check("underrun",    bus.o_underrun,    e_rdy && !gv);
      check("active_ch",   bus.o_active_ch,   m_act);

      if (bus.o_frame_start === 1'b1) begin
        cap_on = 1; cap_pos = 0; cs = '0; cr = '0; cu = '0; cb = 0;
        cch = bus.o_active_ch; cstart = cyc;
      end
      if (cap_on) begin
        if (bus.o_busy !== 1'b1) begin
          if (fcnt < 64) begin
            f_stream[fcnt] = cs; f_rdy[fcnt] = cr; f_und[fcnt] = cu;
            f_busy[fcnt] = cb; f_start[fcnt] = cstart; f_ch[fcnt] = cch;
          end
          fcnt++;
          cap_on = 0;
        end else begin
          if (cap_pos < FLEN) cs = {cs[62:0], bus.o_enc_data};
          if (cap_pos < 64) begin
            cr[cap_pos] = bus.o_ch0_ready | bus.o_ch1_ready;
            cu[cap_pos] = bus.o_underrun;
          end
          cb++;
          cap_pos++;
        end
      end

      if (rst) begin
        m_pos = -1; m_last = 1'b1; m_act = 1'b0;
      end else if (m_pos < 0) begin
        if (bus.i_ch0_valid || bus.i_ch1_valid) begin
          g = (bus.i_ch0_valid && bus.i_ch1_valid) ? !m_last : bus.i_ch1_valid;
          m_act = g; m_last = g;
          m_frame[0] = SYNC;
          m_frame[1] = {7'b0, g};
          m_pos = 0;
        end
      end else begin
        if (e_rdy) begin
          m_frame[2 + (m_pos - 15) / 8] = gv ? gd : 8'h00;
          if (gv) begin
            if (m_act) void'(q1.pop_front());
            else       void'(q0.pop_front());
          end
        end
        m_pos++;
        if (m_pos == FLEN + GAP) m_pos = -1;
      end
      cyc++;
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (fcnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_frames", fcnt >= n, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, k, p, b1, nfs, bad;
    logic [23:0] s1;
    logic [63:0] rm1;
    bit got_rdy;

    bus1.i_ch0_valid = 1'b0; bus1.i_ch1_valid = 1'b0;
    bus1.i_ch0_data  = 8'h00; bus1.i_ch1_data  = 8'h00;

    // Reset held three edges with both channels requesting.
    q0 = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    q1 = '{8'h55};
    en0 = 1; en1 = 1;
    @(posedge clk); #1 started = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {bus.o_busy, bus.o_enc_data, bus.o_ch0_ready, bus.o_ch1_ready,
           bus.o_frame_start, bus.o_active_ch, bus.o_underrun}, 7'b0);
    rst = 0;

    // First tie after reset goes to ch0; ch1 then withdraws.
    k = 0;
    while (bus.o_busy !== 1'b1 && k < 10) begin
      @(posedge clk); #1; k++;
    end
    check("first_grant_ch0", bus.o_active_ch, 1'b0);
    en1 = 0; q1.delete();

    // Two back-to-back ch0 frames.
    wait_frames(2, 300);
    en0 = 0;
    check("t2_stream",     f_stream[0][47:0], 48'h7E00A53CFF01);
    check("t2_ready_cyc",  f_rdy[0], 64'h0000_0080_8080_8000);
    check("t2_busy_len",   f_busy[0], 50);
    check("t2_no_underrun", f_und[0], 64'h0);
    check("t2_period",     f_start[1] - f_start[0], 51);
    check("t2_stream2",    f_stream[1][47:0], 48'h7E0012345678);

    // Ch1 frame with a one-cycle valid drop at the third fetch.
    q1 = '{8'h11, 8'h22, 8'h44};
    drop_pos1 = 31; en1 = 1;
    wait_frames(3, 300);
    drop_pos1 = -2; en1 = 0;
    check("t4_stream",   f_stream[2][47:0], 48'h7E0111220044);
    check("t4_underrun", f_und[2], 64'h0000_0000_8000_0000);
    check("t4_busy_len", f_busy[2], 50);
    check("t4_chan",     f_ch[2], 1'b1);

    // Reset in the middle of a frame, then continuous contention.
    for (int i = 0; i < 16; i++) begin
      q0.push_back(8'($urandom));
      q1.push_back(8'($urandom));
    end
    en0 = 1; en1 = 1;
    k = 0;
    while (m_pos != 20 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("reach_cycle20", m_pos, 20);
    idx = fcnt;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("abort_outputs",
          {bus.o_busy, bus.o_enc_data, bus.o_ch0_ready, bus.o_ch1_ready}, 4'b0);
    wait_frames(idx + 5, 600);
    check("abort_busy_len", f_busy[idx], 21);
    check("post_reset_sync", f_stream[idx + 1][47:40], 8'h7E);
    for (int i = 0; i < 4; i++) begin
      check("rr_grant", f_ch[idx + 1 + i], i % 2);
      check("rr_chid",  f_stream[idx + 1 + i][39:32], i % 2);
    end

    // Random traffic against the model.
    rnd = 1;
    repeat (2500) @(posedge clk);
    rnd = 0; en0 = 0; en1 = 0;
    k = 0;
    while (m_pos >= 0 && k < 100) begin
      @(negedge clk); k++;
    end
    check("drain_idle", m_pos < 0, 1'b1);
    repeat (3) @(posedge clk);

    // Single payload byte, single gap bit instance.
    p = -1; b1 = 0; nfs = 0; bad = 0; s1 = '0; rm1 = '0;
    @(posedge clk); #1;
    rst1 = 0;
    bus1.i_ch0_valid = 1'b1;
    bus1.i_ch0_data  = 8'h81;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus1.o_frame_start === 1'b1) begin p = 0; nfs++; end
      if (p >= 0) begin
        if (p < 24) s1 = {s1[22:0], bus1.o_enc_data};
        if (p < 64 && bus1.o_ch0_ready === 1'b1) rm1[p] = 1'b1;
        p++;
      end
      if (bus1.o_ch1_ready !== 1'b0 || bus1.o_underrun !== 1'b0) bad++;
      if (bus1.o_busy === 1'b1) b1++;
      got_rdy = (bus1.o_ch0_ready === 1'b1);
      @(posedge clk); #1;
      if (got_rdy) bus1.i_ch0_valid = 1'b0;
    end
    check("t6_stream",   s1, 24'h7E0081);
    check("t6_ready",    rm1, 64'h8000);
    check("t6_busy_len", b1, 25);
    check("t6_frames",   nfs, 1);
    check("t6_no_other", bad, 0);
    check("t6_active",   bus1.o_active_ch, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
